// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational 32-bit ALU among NUM_REQ requesters.
//
// Requests are arbitrated round-robin. The winner's op and operands are registered onto
// alu_op/alu_a/alu_b. One cycle later the ALU result is captured and returned to the winner
// under a held valid/ready response. Unsupported ops (4, 12..15) return resp_data=0 and
// resp_err=1.
//
// Ports:
//   clock, reset_L           clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready      per-requester request handshake (req_ready at most one-hot)
//   req_op/req_a/req_b       packed per-requester op (4b) and operands (32b)
//   resp_valid/resp_ready    one-hot response valid to the owner, per-requester accept
//   resp_data/resp_err       captured result / unsupported-op flag
//   alu_op/alu_a/alu_b       registered ALU inputs
//   alu_res                  ALU result
//   busy                     high whenever the FSM is not idle
//
// Optional feature macro: ALU_ARB_LOCK_EN adds req_lock[NUM_REQ-1:0]. A request that is
// accepted with its lock bit set makes that requester the only eligible winner. The lock is
// released by that requester's next request accepted with the lock bit clear.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   reset_L,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_op,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]     req_lock,
`endif
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [31:0]            resp_data,
    output logic                   resp_err,
    output logic [3:0]             alu_op,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    input  logic [31:0]            alu_res,
    output logic                   busy
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             r_state, w_state_next;
    logic [IdxW-1:0]    r_ptr, r_owner;
    logic [3:0]         r_alu_op;
    logic [31:0]        r_alu_a, r_alu_b;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [31:0]        r_resp_data;
    logic               r_resp_err;

    logic [NUM_REQ-1:0] w_cand;
    logic               w_win_found;
    logic [IdxW-1:0]    w_win_idx;
    int unsigned        w_scan;
    logic               w_resp_hs;
    logic               w_can_accept;
    logic               w_accept;
    logic               w_unsupported;

`ifdef ALU_ARB_LOCK_EN
    logic               r_locked;
    logic [IdxW-1:0]    r_lock_owner;
`endif

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_cand = req_valid;
`ifdef ALU_ARB_LOCK_EN
        if (r_locked) begin
            w_cand = req_valid & (NUM_REQ'(1) << r_lock_owner);
        end
`endif
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_scan = (32'(r_ptr) + i) % NUM_REQ;
            if (!w_win_found && w_cand[IdxW'(w_scan)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IdxW'(w_scan);
            end
        end
    end

    // Only the owner's resp_ready matters; a new request can ride on the response handshake.
    assign w_resp_hs    = (r_state == StResp) && resp_ready[r_owner];
    assign w_can_accept = (r_state == StIdle) || w_resp_hs;
    assign w_accept     = w_can_accept && w_win_found;
    assign w_unsupported = (r_alu_op == 4'd4) || (r_alu_op >= 4'd12);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = StExec;
            StExec: w_state_next = StResp;
            StResp: begin
                if (w_resp_hs) begin
                    w_state_next = w_accept ? StExec : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state      <= StIdle;
            r_ptr        <= IdxW'(NUM_REQ - 1);
            r_owner      <= '0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_owner  <= w_win_idx;
                r_ptr    <= w_win_idx;
                r_alu_op <= req_op[4*w_win_idx +: 4];
                r_alu_a  <= req_a[32*w_win_idx +: 32];
                r_alu_b  <= req_b[32*w_win_idx +: 32];
            end
            if (r_state == StExec) begin
                r_resp_valid <= NUM_REQ'(1) << r_owner;
                r_resp_data  <= w_unsupported ? 32'd0 : alu_res;
                r_resp_err   <= w_unsupported;
            end else if (w_resp_hs) begin
                r_resp_valid <= '0;
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // Every accept while locked comes from the lock owner, so the new lock bit decides.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_locked     <= 1'b0;
            r_lock_owner <= '0;
        end else if (w_accept) begin
            r_locked     <= req_lock[w_win_idx];
            r_lock_owner <= w_win_idx;
        end
    end
`endif

    // Gated by reset so every output reads 0 while reset is held.
    assign req_ready  = (w_accept && reset_L) ? (NUM_REQ'(1) << w_win_idx) : '0;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign busy       = (r_state != StIdle);

endmodule
